sync_fifo_prog: RTL and testbench

//  Parametrised single-clock FIFO, successor to the fixed-threshold FIFO. Adds runtime-programmable

---
 rtl/sync_fifo_pkg.sv | 35 +++
 rtl/sync_fifo_ram.sv | 32 +++
 rtl/sync_fifo_prog.sv | 183 ++++++++++++++++++
 tb/tb_sync_fifo_prog.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and types for the programmable synchronous FIFO family:
// read-mode encodings, default threshold margins and the per-cycle
// operation encoding used by the level bookkeeping.
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    // Read-mode encodings for the FWFT parameter
    localparam int FIFO_MODE_REG  = 0;  // registered read, data one cycle after accept
    localparam int FIFO_MODE_FWFT = 1;  // show-ahead, head visible at the output

    // Default threshold margins, measured from the full / empty ends
    localparam int FIFO_AFULL_MARGIN_DEF  = 2;
    localparam int FIFO_AEMPTY_MARGIN_DEF = 2;

    // Accepted operations in one cycle, encoded as {write, read}
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_RD   = 2'b01,
        FIFO_OP_WR   = 2'b10,
        FIFO_OP_RDWR = 2'b11
    } fifo_op_e;

    // Default almost-full threshold for a given depth
    function automatic int default_afull_th(input int depth);
        return (depth > FIFO_AFULL_MARGIN_DEF) ? depth - FIFO_AFULL_MARGIN_DEF : depth;
    endfunction

    // Default almost-empty threshold for a given depth
    function automatic int default_aempty_th(input int depth);
        return (depth > FIFO_AEMPTY_MARGIN_DEF) ? FIFO_AEMPTY_MARGIN_DEF : 0;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATA_W storage for sync_fifo_prog: one synchronous write port and
// one asynchronous (combinational) read port. No reset on the array.
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry on an enabled write
    // NOTE: the array has no reset; resetting it would force flops instead of
    // RAM and nothing ever reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with runtime-programmable almost-full / almost-empty
// thresholds, fill-level output, show-ahead or registered read mode,
// synchronous flush and sticky overflow / underflow flags.
//
// Build option: define SYNC_FIFO_PEAK_EN to build the high-water-mark
// register behind o_peak; otherwise o_peak is tied to zero.
// ---------------------------------------------------------------------------
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int FWFT   = FIFO_MODE_FWFT,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    input  logic [LVL_W-1:0]  i_afull_th,
    input  logic [LVL_W-1:0]  i_aempty_th,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [LVL_W-1:0]  o_level,
    input  logic              i_clr_err,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic [LVL_W-1:0]  o_peak
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_do;
    logic              rd_do;
    fifo_op_e          op;
    logic [DATA_W-1:0] ram_rdata;
    logic              overflow_q;
    logic              underflow_q;

    // Advance a pointer, wrapping from DEPTH-1 to 0 (DEPTH need not be 2^n)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Status flags derive from the registered level only
    assign o_full  = (level == LVL_W'(DEPTH));
    assign o_empty = (level == '0);
    assign o_level = level;

    // Threshold comparisons are live: a threshold change shows up at once
    assign o_alm_full  = (level >= i_afull_th);
    assign o_alm_empty = (level <= i_aempty_th);

    // Accepts exclude the rejected side; a flush suppresses both
    assign wr_acc = i_wren & ~o_full;
    assign rd_acc = i_rden & ~o_empty;
    assign wr_do  = wr_acc & ~i_flush;
    assign rd_do  = rd_acc & ~i_flush;
    assign op     = fifo_op_e'({wr_do, rd_do});

    // Next occupancy from the accepted operation mix
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        level_nxt = level;
        if (i_flush) begin
            level_nxt = '0;
        end else begin
            case (op)
                FIFO_OP_WR: level_nxt = level + LVL_W'(1);
                FIFO_OP_RD: level_nxt = level - LVL_W'(1);
                default:    level_nxt = level;
            endcase
        end
    end

    // Pointer and level registers; flush returns both pointers to 0
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values and evaluation order cannot change the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_do) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_do) rd_ptr <= ptr_inc(rd_ptr);
            level <= level_nxt;
        end
    end

    // Sticky error flags: a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_wren & o_full)  overflow_q <= 1'b1;
            else if (i_clr_err)   overflow_q <= 1'b0;
            if (i_rden & o_empty) underflow_q <= 1'b1;
            else if (i_clr_err)   underflow_q <= 1'b0;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_do),
        .wr_addr (wr_ptr),
        .wr_data (i_wrdata),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Show-ahead: the head entry is presented whenever one exists
            assign o_rddata  = o_empty ? '0 : ram_rdata;
            assign o_rdvalid = ~o_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read: capture the head on an accepted read and
            // hold it until the next one; valid pulses for one cycle
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_do;
                    if (rd_do) rd_data_q <= ram_rdata;
                end
            end

            assign o_rddata  = rd_data_q;
            assign o_rdvalid = rd_valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_PEAK_EN
    logic [LVL_W-1:0] peak_q;

    // High-water mark of the occupancy; cleared together with the errors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else if (i_clr_err) begin
            peak_q <= '0;
        end else if (level_nxt > peak_q) begin
            peak_q <= level_nxt;
        end
    end

    assign o_peak = peak_q;
`else
    assign o_peak = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
// Directed bench for sync_fifo_prog at DEPTH=8, DATA_W=16. Two instances
// share every input: u_fwft (show-ahead) and u_reg (registered read).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_fifo_prog;
    import sync_fifo_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = 4;
`ifdef SYNC_FIFO_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              i_flush, i_wren, i_rden, i_clr_err;
    logic [DATA_W-1:0] i_wrdata;
    logic [LVL_W-1:0]  i_afull_th, i_aempty_th;

    logic [DATA_W-1:0] f_rddata, r_rddata;
    logic              f_rdvalid, r_rdvalid, f_full, r_full, f_empty, r_empty;
    logic              f_alm_full, r_alm_full, f_alm_empty, r_alm_empty;
    logic [LVL_W-1:0]  f_level, r_level, f_peak, r_peak;
    logic              f_overflow, r_overflow, f_underflow, r_underflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(FIFO_MODE_FWFT)) u_fwft (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
        .i_rden(i_rden), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full),
        .o_empty(f_empty), .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th),
        .o_alm_full(f_alm_full), .o_alm_empty(f_alm_empty), .o_level(f_level),
        .i_clr_err(i_clr_err), .o_overflow(f_overflow), .o_underflow(f_underflow), .o_peak(f_peak)
    );

    sync_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(FIFO_MODE_REG)) u_reg (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
        .i_rden(i_rden), .o_rddata(r_rddata), .o_rdvalid(r_rdvalid), .o_full(r_full),
        .o_empty(r_empty), .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th),
        .o_alm_full(r_alm_full), .o_alm_empty(r_alm_empty), .o_level(r_level),
        .i_clr_err(i_clr_err), .o_overflow(r_overflow), .o_underflow(r_underflow), .o_peak(r_peak)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_flush = 0; i_wren = 0; i_rden = 0; i_clr_err = 0; i_wrdata = '0;
        i_afull_th = 4'd6; i_aempty_th = 4'd2;
        #12;
        vectors++; if (f_level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", f_level); end
        vectors++; if (f_empty !== 1'b1 || f_full !== 1'b0) begin miscompares++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", f_empty, f_full); end
        vectors++; if (f_rdvalid !== 1'b0 || r_rdvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rdvalid fwft=%b reg=%b exp 0", f_rdvalid, r_rdvalid); end
        vectors++; if (f_rddata !== 16'h0 || r_rddata !== 16'h0) begin miscompares++; $display("FAIL reset_rddata fwft=%h reg=%h exp 0", f_rddata, r_rddata); end
        vectors++; if (f_overflow !== 1'b0 || f_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err ov=%b un=%b exp 0/0", f_overflow, f_underflow); end
        vectors++; if (f_alm_empty !== 1'b1 || f_alm_full !== 1'b0) begin miscompares++; $display("FAIL reset_alm ae=%b af=%b exp 1/0", f_alm_empty, f_alm_full); end
        vectors++; if (f_peak !== 4'd0 || r_peak !== 4'd0) begin miscompares++; $display("FAIL reset_peak got %0d/%0d exp 0", f_peak, r_peak); end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
    endtask

    // Fill 1..8 with afull=6 / aempty=2, then one rejected write
    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            i_wren = 1'b1; i_wrdata = 16'(i);
            tick();
            vectors++; if (f_level !== 4'(i)) begin miscompares++; $display("FAIL fill_level got %0d exp %0d", f_level, i); end
            vectors++; if (f_full !== (i == 8)) begin miscompares++; $display("FAIL fill_full got %b exp %b at %0d", f_full, (i == 8), i); end
            vectors++; if (f_alm_full !== (i >= 6) || f_alm_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_alm af=%b ae=%b at level %0d", f_alm_full, f_alm_empty, i); end
            vectors++; if (f_rddata !== 16'h0001) begin miscompares++; $display("FAIL fill_head got %h exp 0001", f_rddata); end
        end
        i_wrdata = 16'h0009;
        tick();
        i_wren = 1'b0;
        vectors++; if (f_overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set got %b exp 1", f_overflow); end
        vectors++; if (f_level !== 4'd8) begin miscompares++; $display("FAIL overflow_level got %0d exp 8", f_level); end
        vectors++; if (f_underflow !== 1'b0) begin miscompares++; $display("FAIL overflow_no_underflow got %b exp 0", f_underflow); end
    endtask

    // Threshold inputs act combinationally at level 8
    task automatic test_threshold_change();
        i_afull_th = 4'd9; #1;
        vectors++; if (f_alm_full !== 1'b0) begin miscompares++; $display("FAIL th_afull9 got %b exp 0", f_alm_full); end
        i_afull_th = 4'd8; #1;
        vectors++; if (f_alm_full !== 1'b1) begin miscompares++; $display("FAIL th_afull8 got %b exp 1", f_alm_full); end
        i_aempty_th = 4'd8; #1;
        vectors++; if (f_alm_empty !== 1'b1) begin miscompares++; $display("FAIL th_aempty8 got %b exp 1", f_alm_empty); end
        i_aempty_th = 4'd7; #1;
        vectors++; if (f_alm_empty !== 1'b0) begin miscompares++; $display("FAIL th_aempty7 got %b exp 0", f_alm_empty); end
        i_afull_th = 4'd6; i_aempty_th = 4'd2;
    endtask

    // Read and write together while full: only the read happens
    task automatic test_full_rdwr();
        i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 16'h0099;
        tick();
        i_wren = 1'b0; i_rden = 1'b0;
        vectors++; if (f_level !== 4'd7) begin miscompares++; $display("FAIL full_rdwr_level got %0d exp 7", f_level); end
        vectors++; if (f_rddata !== 16'h0002) begin miscompares++; $display("FAIL full_rdwr_head got %h exp 0002", f_rddata); end
    endtask

    // Drain 7..0, checking order and the almost-empty edge at level 2
    task automatic test_drain_thresholds();
        for (int lvl = 7; lvl >= 1; lvl--) begin
            vectors++; if (f_rddata !== 16'(9 - lvl)) begin miscompares++; $display("FAIL drain_data got %h exp %h", f_rddata, 16'(9 - lvl)); end
            i_rden = 1'b1;
            tick();
            vectors++; if (f_level !== 4'(lvl - 1)) begin miscompares++; $display("FAIL drain_level got %0d exp %0d", f_level, lvl - 1); end
            vectors++; if (f_alm_empty !== (lvl - 1 <= 2) || f_alm_full !== (lvl - 1 >= 6)) begin miscompares++; $display("FAIL drain_alm ae=%b af=%b at level %0d", f_alm_empty, f_alm_full, lvl - 1); end
        end
        i_rden = 1'b0;
        vectors++; if (f_empty !== 1'b1 || f_rdvalid !== 1'b0 || f_rddata !== 16'h0) begin miscompares++; $display("FAIL drain_empty empty=%b valid=%b data=%h exp 1/0/0000", f_empty, f_rdvalid, f_rddata); end
    endtask

    // Read and write together while empty: only the write happens
    task automatic test_empty_rdwr();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        vectors++; if (f_overflow !== 1'b0 || f_underflow !== 1'b0) begin miscompares++; $display("FAIL clr_err ov=%b un=%b exp 0/0", f_overflow, f_underflow); end
        i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 16'h00AA;
        tick();
        i_wren = 1'b0;
        vectors++; if (f_level !== 4'd1) begin miscompares++; $display("FAIL empty_rdwr_level got %0d exp 1", f_level); end
        vectors++; if (f_underflow !== 1'b1) begin miscompares++; $display("FAIL empty_rdwr_underflow got %b exp 1", f_underflow); end
        vectors++; if (f_rddata !== 16'h00AA || f_rdvalid !== 1'b1) begin miscompares++; $display("FAIL empty_rdwr_head data=%h valid=%b exp 00aa/1", f_rddata, f_rdvalid); end
        tick();
        i_rden = 1'b0;
        vectors++; if (f_level !== 4'd0) begin miscompares++; $display("FAIL empty_rdwr_drain got %0d exp 0", f_level); end
    endtask

    // 20 words streamed at level 4, crossing the pointer wrap
    task automatic test_back_to_back();
        int rd_n;
        rd_n = 0;
        for (int k = 0; k < 20; k++) begin
            i_wren = 1'b1; i_wrdata = 16'h1000 + 16'(k);
            i_rden = (k >= 4);
            if (k >= 4) begin
                vectors++; if (f_rddata !== 16'h1000 + 16'(rd_n)) begin miscompares++; $display("FAIL stream_data got %h exp %h", f_rddata, 16'h1000 + 16'(rd_n)); end
                rd_n++;
            end
            tick();
            vectors++; if (f_level !== ((k < 4) ? 4'(k + 1) : 4'd4)) begin miscompares++; $display("FAIL stream_level got %0d at k=%0d", f_level, k); end
        end
        i_wren = 1'b0; i_rden = 1'b1;
        while (rd_n < 20) begin
            vectors++; if (f_rddata !== 16'h1000 + 16'(rd_n)) begin miscompares++; $display("FAIL stream_tail got %h exp %h", f_rddata, 16'h1000 + 16'(rd_n)); end
            rd_n++;
            tick();
        end
        i_rden = 1'b0;
        vectors++; if (f_empty !== 1'b1) begin miscompares++; $display("FAIL stream_empty got %b exp 1", f_empty); end
    endtask

    // Registered-read instance: one-cycle latency and held data
    task automatic test_registered_read();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        i_wren = 1'b1; i_wrdata = 16'hAAAA;
        tick();
        i_wren = 1'b0;
        vectors++; if (r_rdvalid !== 1'b0 || r_rddata !== 16'h1013) begin miscompares++; $display("FAIL reg_idle valid=%b data=%h exp 0/1013", r_rdvalid, r_rddata); end
        i_rden = 1'b1;
        tick();
        i_rden = 1'b0;
        vectors++; if (r_rdvalid !== 1'b1 || r_rddata !== 16'hAAAA) begin miscompares++; $display("FAIL reg_read valid=%b data=%h exp 1/aaaa", r_rdvalid, r_rddata); end
        vectors++; if (r_level !== 4'd0) begin miscompares++; $display("FAIL reg_level got %0d exp 0", r_level); end
        tick();
        vectors++; if (r_rdvalid !== 1'b0 || r_rddata !== 16'hAAAA) begin miscompares++; $display("FAIL reg_hold valid=%b data=%h exp 0/aaaa", r_rdvalid, r_rddata); end
        i_rden = 1'b1;
        tick();
        i_rden = 1'b0;
        vectors++; if (r_underflow !== 1'b1 || r_rdvalid !== 1'b0 || r_rddata !== 16'hAAAA) begin miscompares++; $display("FAIL reg_underflow un=%b valid=%b data=%h exp 1/0/aaaa", r_underflow, r_rdvalid, r_rddata); end
    endtask

    // Flush against a same-cycle write; error flags and peak survive
    task automatic test_flush();
        i_clr_err = 1'b1; i_rden = 1'b1;
        tick();
        i_clr_err = 1'b0; i_rden = 1'b0;
        vectors++; if (f_underflow !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear got %b exp 1", f_underflow); end
        vectors++; if (f_peak !== 4'd0) begin miscompares++; $display("FAIL peak_cleared got %0d exp 0", f_peak); end
        for (int k = 0; k < 5; k++) begin
            i_wren = 1'b1; i_wrdata = 16'h5000 + 16'(k);
            tick();
        end
        vectors++; if (f_level !== 4'd5) begin miscompares++; $display("FAIL flush_pre_level got %0d exp 5", f_level); end
        i_flush = 1'b1; i_wrdata = 16'hFFFF;
        tick();
        i_flush = 1'b0; i_wren = 1'b0;
        vectors++; if (f_level !== 4'd0 || f_empty !== 1'b1) begin miscompares++; $display("FAIL flush_level level=%0d empty=%b exp 0/1", f_level, f_empty); end
        vectors++; if (f_rdvalid !== 1'b0 || r_rdvalid !== 1'b0 || f_rddata !== 16'h0) begin miscompares++; $display("FAIL flush_rdvalid fwft=%b reg=%b data=%h exp 0/0/0000", f_rdvalid, r_rdvalid, f_rddata); end
        vectors++; if (f_underflow !== 1'b1 || f_overflow !== 1'b0) begin miscompares++; $display("FAIL flush_err un=%b ov=%b exp 1/0", f_underflow, f_overflow); end
        vectors++; if (f_peak !== (PEAK_EN ? 4'd5 : 4'd0)) begin miscompares++; $display("FAIL flush_peak got %0d exp %0d", f_peak, PEAK_EN ? 5 : 0); end
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        vectors++; if (f_underflow !== 1'b0 || f_peak !== 4'd0) begin miscompares++; $display("FAIL clr_after_flush un=%b peak=%0d exp 0/0", f_underflow, f_peak); end
        i_wren = 1'b1; i_wrdata = 16'h1234;
        tick();
        i_wren = 1'b0;
        vectors++; if (f_rddata !== 16'h1234 || f_level !== 4'd1) begin miscompares++; $display("FAIL post_flush_write data=%h level=%0d exp 1234/1", f_rddata, f_level); end
    endtask

    // Async reset in the middle of a cycle with traffic in flight
    task automatic test_async_reset();
        i_rden = 1'b1;
        tick();
        tick();
        i_rden = 1'b0;
        vectors++; if (f_underflow !== 1'b1 || r_rddata !== 16'h1234) begin miscompares++; $display("FAIL pre_reset un=%b regdata=%h exp 1/1234", f_underflow, r_rddata); end
        for (int k = 0; k < 3; k++) begin
            i_wren = 1'b1; i_wrdata = 16'h7000 + 16'(k);
            tick();
        end
        #3 reset = 1'b0;
        #1;
        vectors++; if (f_level !== 4'd0 || f_empty !== 1'b1 || f_full !== 1'b0) begin miscompares++; $display("FAIL areset_level level=%0d empty=%b full=%b", f_level, f_empty, f_full); end
        vectors++; if (f_rddata !== 16'h0 || r_rddata !== 16'h0 || r_rdvalid !== 1'b0 || f_rdvalid !== 1'b0) begin miscompares++; $display("FAIL areset_data fwft=%h reg=%h", f_rddata, r_rddata); end
        vectors++; if (f_underflow !== 1'b0 || f_overflow !== 1'b0 || f_peak !== 4'd0) begin miscompares++; $display("FAIL areset_err un=%b ov=%b peak=%0d", f_underflow, f_overflow, f_peak); end
        i_wren = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        vectors++; if (f_level !== 4'd0 || f_alm_empty !== 1'b1) begin miscompares++; $display("FAIL post_reset level=%0d ae=%b exp 0/1", f_level, f_alm_empty); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_threshold_change();
        test_full_rdwr();
        test_drain_thresholds();
        test_empty_rdwr();
        test_back_to_back();
        test_registered_read();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
